// File: rtl/clk_freq_meter_pkg.sv
// Shared state encoding and helpers for the clock frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    IDLE   = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } fm_state_t;

  localparam int GATE_CYCLES_DEFAULT = 30000;

  // Gate counter must hold the values 0..GATE_CYCLES.
  function automatic int gate_cnt_width(input int gate_cycles);
    return $clog2(gate_cycles + 1);
  endfunction

  localparam int GATE_CNT_W_DEFAULT = gate_cnt_width(GATE_CYCLES_DEFAULT);

  function automatic logic in_window(input int unsigned value,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/clk_freq_meter_if.sv
// Request/result bundle between the frequency meter and its user.
interface clk_freq_meter_if #(
  parameter int COUNT_W = 16
);
  logic               meas_in;
  logic               start;
  logic               busy;
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic               in_range;
  logic               valid;

  modport master (
    output meas_in,
    output start,
    input  busy,
    input  count,
    input  overflow,
    input  in_range,
    input  valid
  );

  modport slave (
    input  meas_in,
    input  start,
    output busy,
    output count,
    output overflow,
    output in_range,
    output valid
  );
endinterface

// File: rtl/clk_freq_meter_sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous clock plus rising-edge detector.
module sync_edge_detect
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter that measures meas_in against clk and judges the result.
// Optional feature macro: FREQ_METER_CONTINUOUS_EN (back-to-back gates after one start).
module clk_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 30000,
  parameter int COUNT_W     = 16,
  parameter int EXP_MIN     = 990,
  parameter int EXP_MAX     = 1010,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  clk_freq_meter_if.slave fm
);

  localparam int GATE_CNT_W   = gate_cnt_width(GATE_CYCLES);
  localparam int SETTLE_CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [GATE_CNT_W-1:0]   GATE_LAST   = GATE_CNT_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SYNC_STAGES);
  localparam logic [COUNT_W-1:0]      COUNT_MAX   = '1;

  if (EXP_MIN > EXP_MAX) begin : g_bad_range
    $error("clk_freq_meter: EXP_MIN must not exceed EXP_MAX");
  end
  if (GATE_CYCLES < 2) begin : g_bad_gate
    $error("clk_freq_meter: GATE_CYCLES must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("clk_freq_meter: SYNC_STAGES must be at least 2");
  end

  fm_state_t                state_q;
  fm_state_t                state_d;
  logic [SETTLE_CNT_W-1:0]  settle_q;
  logic [SETTLE_CNT_W-1:0]  settle_d;
  logic [GATE_CNT_W-1:0]    gate_q;
  logic [GATE_CNT_W-1:0]    gate_d;
  logic [COUNT_W-1:0]       edges_q;
  logic [COUNT_W-1:0]       edges_d;
  logic [COUNT_W-1:0]       edges_inc_s;
  logic                     ovf_q;
  logic                     ovf_d;
  logic                     ovf_inc_s;
  logic [COUNT_W-1:0]       count_q;
  logic [COUNT_W-1:0]       count_d;
  logic                     overflow_q;
  logic                     overflow_d;
  logic                     in_range_q;
  logic                     in_range_d;
  logic                     valid_q;
  logic                     valid_d;
  logic                     rise_s;
  logic                     busy_s;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (fm.meas_in),
    .level    (),
    .rise     (rise_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
        end
      end
      IDLE: begin
        if (fm.start) begin
          state_d = GATE;
        end else begin
          state_d = IDLE;
        end
      end
      GATE: begin
        if (gate_q == GATE_LAST) begin
          state_d = DONE;
        end else begin
          state_d = GATE;
        end
      end
      DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
        state_d = GATE;
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = SETTLE;
      end
    endcase
  end

  always_comb begin
    busy_s = 1'b1;
    case (state_q)
      IDLE:    busy_s = 1'b0;
      default: busy_s = 1'b1;
    endcase
  end

  // An edge arriving at full scale leaves the count pinned and flags overflow.
  always_comb begin
    edges_inc_s = edges_q;
    ovf_inc_s   = ovf_q;
    if (rise_s) begin
      if (edges_q == COUNT_MAX) begin
        ovf_inc_s = 1'b1;
      end else begin
        edges_inc_s = edges_q + COUNT_W'(1);
      end
    end else begin
      edges_inc_s = edges_q;
    end
  end

  always_comb begin
    settle_d   = settle_q;
    gate_d     = gate_q;
    edges_d    = edges_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    in_range_d = in_range_q;
    valid_d    = 1'b0;
    case (state_q)
      SETTLE: begin
        if (settle_q != SETTLE_LAST) begin
          settle_d = settle_q + SETTLE_CNT_W'(1);
        end else begin
          settle_d = settle_q;
        end
      end
      IDLE: begin
        if (fm.start) begin
          gate_d  = '0;
          edges_d = '0;
          ovf_d   = 1'b0;
        end else begin
          gate_d  = gate_q;
        end
      end
      GATE: begin
        gate_d  = gate_q + GATE_CNT_W'(1);
        edges_d = edges_inc_s;
        ovf_d   = ovf_inc_s;
        // The final gate cycle's edge goes straight into the published result.
        if (gate_q == GATE_LAST) begin
          count_d    = edges_inc_s;
          overflow_d = ovf_inc_s;
          in_range_d = ~ovf_inc_s & in_window(32'(edges_inc_s), 32'(EXP_MIN), 32'(EXP_MAX));
          valid_d    = 1'b1;
        end else begin
          valid_d    = 1'b0;
        end
      end
      DONE: begin
        gate_d  = '0;
        edges_d = '0;
        ovf_d   = 1'b0;
      end
      default: begin
        settle_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q   <= '0;
      gate_q     <= '0;
      edges_q    <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      in_range_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      settle_q   <= settle_d;
      gate_q     <= gate_d;
      edges_q    <= edges_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      in_range_q <= in_range_d;
      valid_q    <= valid_d;
    end
  end

  assign fm.busy     = busy_s;
  assign fm.count    = count_q;
  assign fm.overflow = overflow_q;
  assign fm.in_range = in_range_q;
  assign fm.valid    = valid_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench: two meters (16-bit and 3-bit counters) share one stimulus.
`timescale 1ns/1ps
module tb_clk_freq_meter;

  localparam int G      = 300;
  localparam int S      = 2;
  localparam int EMIN   = 9;
  localparam int EMAX   = 11;
  localparam int CWA    = 16;
  localparam int CWB    = 3;
  localparam int BMAX   = (1 << CWB) - 1;
  localparam int HIST_N = 65536;

  typedef struct {
    int mode;
    int period;
    int exp_a_cnt;
    int exp_a_inr;
    int exp_b_cnt;
    int exp_b_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   mode;
  int   period;
  int   phase;
  int   dens;
  int   cyc;
  int   n_vec;
  int   n_bad;
  int   busy_lows;
  bit   meas_v;
  bit   hist [HIST_N];
  vec_t tbl [5];

  clk_freq_meter_if #(.COUNT_W(CWA)) if_a ();
  clk_freq_meter_if #(.COUNT_W(CWB)) if_b ();

  clk_freq_meter #(.GATE_CYCLES(G), .COUNT_W(CWA), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
                   .SYNC_STAGES(S)) u_dut_a (.clk(clk), .rst(rst), .fm(if_a));
  clk_freq_meter #(.GATE_CYCLES(G), .COUNT_W(CWB), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
                   .SYNC_STAGES(S)) u_dut_b (.clk(clk), .rst(rst), .fm(if_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // meas_in is driven once per clk cycle and its history kept for the model.
  initial begin
    cyc = 0;
    meas_v = 1'b0;
    if_a.meas_in = 1'b0;
    if_b.meas_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (mode)
        1:       meas_v = ((cyc + phase) % period) < (period / 2);
        2:       meas_v = ($urandom_range(99, 0) < dens);
        3:       meas_v = 1'b1;
        default: meas_v = 1'b0;
      endcase
      if_a.meas_in = meas_v;
      if_b.meas_in = meas_v;
      if (cyc < HIST_N) hist[cyc] = meas_v;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: after S synchronizer cycles a rising transition of meas_in is seen;
  // the gate opened by a start in cycle t covers input cycles t+1-S .. t+G-S.
  function automatic int model_edges(input int t);
    int n;
    n = 0;
    for (int c = t + 1 - S; c <= t + G - S; c++) begin
      if (c >= 1 && c < HIST_N && hist[c] && !hist[c-1]) n++;
    end
    return n;
  endfunction

  task automatic set_start(input logic v);
    if_a.start = v;
    if_b.start = v;
  endtask

  task automatic pulse_start(output int t);
    @(posedge clk); #2;
    set_start(1'b1);
    t = cyc;
    @(posedge clk); #2;
    set_start(1'b0);
  endtask

  task automatic wait_valid(input int budget, output int vcyc);
    vcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_a.busy !== 1'b1) busy_lows++;
      if (if_a.valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},     32'(if_a.busy),     32'd1);
    chk({tag, "_valid"},    32'(if_a.valid),    32'd0);
    chk({tag, "_count"},    32'(if_a.count),    32'd0);
    chk({tag, "_overflow"}, 32'(if_a.overflow), 32'd0);
    chk({tag, "_in_range"}, 32'(if_a.in_range), 32'd0);
    chk({tag, "_count_b"},  32'(if_b.count),    32'd0);
  endtask

  // Called just after rst falls; optionally pokes start through the settle window.
  task automatic check_settle(input string tag, input bit poke);
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_a.busy !== 1'b1) break;
      n++;
      if (poke && i == 0) begin
        @(posedge clk); #2;
        set_start(1'b1);
      end else if (poke && i == 2) begin
        @(posedge clk); #2;
        set_start(1'b0);
      end
    end
    set_start(1'b0);
    chk({tag, "_settle_len"}, 32'(n), 32'(S + 1));
  endtask

  task automatic measure(input string tag, input int ea, input int einr,
                         input int eb, input int ebovf, input bit use_model);
    int t;
    int v;
    int n;
    int ebinr;
    pulse_start(t);
    busy_lows = 0;
    wait_valid(G + 50, v);
    if (use_model) begin
      n     = model_edges(t);
      ea    = n;
      einr  = (n >= EMIN && n <= EMAX) ? 1 : 0;
      eb    = (n > BMAX) ? BMAX : n;
      ebovf = (n > BMAX) ? 1 : 0;
    end
    ebinr = (ebovf == 0 && eb >= EMIN && eb <= EMAX) ? 1 : 0;
    chk({tag, "_latency"},   32'(v - t),         32'(G + 1));
    chk({tag, "_count"},     32'(if_a.count),    32'(ea));
    chk({tag, "_overflow"},  32'(if_a.overflow), 32'd0);
    chk({tag, "_in_range"},  32'(if_a.in_range), 32'(einr));
    chk({tag, "_count_b"},   32'(if_b.count),    32'(eb));
    chk({tag, "_ovf_b"},     32'(if_b.overflow), 32'(ebovf));
    chk({tag, "_inr_b"},     32'(if_b.in_range), 32'(ebinr));
    chk({tag, "_busy_gate"}, 32'(busy_lows),     32'd0);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, 32'(if_a.valid), 32'd0);
`ifndef FREQ_METER_CONTINUOUS_EN
    chk({tag, "_idle_busy"},  32'(if_a.busy),  32'd0);
`endif
  endtask

  initial begin
    int t;
    int v;
    int prev;
    int n_valid;
    int n_busy;
    int cnt_first;
    n_vec = 0;
    n_bad = 0;
    busy_lows = 0;
    mode = 3;
    period = 30;
    phase = 0;
    dens = 50;
    rst = 1'b1;
    set_start(1'b0);

    tbl[0] = '{1, 30, 10, 1, 7, 1};
    tbl[1] = '{1, 25, 12, 0, 7, 1};
    tbl[2] = '{0,  0,  0, 0, 0, 0};
    tbl[3] = '{1, 50,  6, 0, 6, 0};
    tbl[4] = '{1, 20, 15, 0, 7, 1};

    repeat (4) @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #2;
    rst = 1'b0;
    check_settle("por", 1'b1);
    n_valid = 0;
    n_busy = 0;
    repeat (G + 100) begin
      @(negedge clk);
      if (if_a.valid === 1'b1) n_valid++;
      if (if_a.busy === 1'b1) n_busy++;
    end
    chk("settle_start_valids", 32'(n_valid), 32'd0);
    chk("settle_start_busy", 32'(n_busy), 32'd0);

`ifdef FREQ_METER_CONTINUOUS_EN
    // DONE is the only dead cycle, so results repeat every G+1 cycles.
    mode = 1; period = 30; phase = 7;
    repeat (40) @(posedge clk);
    pulse_start(t);
    prev = t;
    busy_lows = 0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(G + 50, v);
      chk($sformatf("cont%0d_spacing", k), 32'(v - prev), 32'(G + 1));
      chk($sformatf("cont%0d_count", k), 32'(if_a.count), 32'd10);
      chk($sformatf("cont%0d_in_range", k), 32'(if_a.in_range), 32'd1);
      chk($sformatf("cont%0d_count_b", k), 32'(if_b.count), 32'(BMAX));
      prev = v;
    end
    chk("cont_busy_low", 32'(busy_lows), 32'd0);
`else
    measure("hold_high", 0, 0, 0, 0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      period = tbl[i].period;
      if (period > 0) phase = int'($urandom_range(period - 1, 0));
      repeat (40) @(posedge clk);
      measure($sformatf("vec%0d", i), tbl[i].exp_a_cnt, tbl[i].exp_a_inr,
              tbl[i].exp_b_cnt, tbl[i].exp_b_ovf, 1'b0);
    end

    for (int r = 0; r < 6; r++) begin
      if (r < 3) begin
        mode = 2;
        dens = int'($urandom_range(90, 10));
      end else begin
        mode = 1;
        period = int'($urandom_range(60, 4));
        phase = int'($urandom_range(period - 1, 0));
      end
      repeat (20 + int'($urandom_range(30, 0))) @(posedge clk);
      measure($sformatf("rnd%0d", r), 0, 0, 0, 0, 1'b1);
    end

    mode = 1; period = 30; phase = 3;
    repeat (40) @(posedge clk);
    pulse_start(t);
    n_valid = 0;
    cnt_first = -1;
    v = -1;
    repeat (100) begin
      @(negedge clk);
      if (if_a.valid === 1'b1) n_valid++;
    end
    @(posedge clk); #2;
    set_start(1'b1);
    @(posedge clk); #2;
    set_start(1'b0);
    repeat (G + 200) begin
      @(negedge clk);
      if (if_a.valid === 1'b1) begin
        n_valid++;
        if (n_valid == 1) begin
          v = cyc;
          cnt_first = int'(if_a.count);
        end
      end
    end
    chk("midstart_valids", 32'(n_valid), 32'd1);
    chk("midstart_latency", 32'(v - t), 32'(G + 1));
    chk("midstart_count", 32'(cnt_first), 32'd10);

    pulse_start(t);
    while (cyc < t + 150) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    #1;
    chk_reset_vals("midgate");
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    check_settle("midgate", 1'b0);
    measure("after_rst", 10, 1, 7, 1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
